// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM burst master.
// Holds the controller state encoding and the default address, data and
// burst-length widths used by sram_master and sram_burst_cnt.
package sram_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

endpackage

// File: rtl/sram_burst_cnt.sv
// Burst address / beat counter.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load_i       capture addr_ld_i / len_ld_i (start of a burst)
//   step_i       one beat completed: advance address, count beats down
//   addr_ld_i    burst start address
//   len_ld_i     beats minus one
//   addr_o       current beat address (wraps modulo 2^ADDR_W)
//   last_o       current beat is the final one of the burst
module sram_burst_cnt #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] addr_ld_i,
  input  logic [LEN_W-1:0]  len_ld_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  beat_q, beat_d;

  always_comb begin
    addr_d = addr_q;
    beat_d = beat_q;
    if (load_i) begin
      addr_d = addr_ld_i;
      beat_d = len_ld_i;
    end else if (step_i) begin
      // Natural overflow of the ADDR_W-bit add gives the required wrap.
      addr_d = addr_q + ADDR_W'(1);
      beat_d = beat_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      beat_q <= '0;
    end else begin
      addr_q <= addr_d;
      beat_q <= beat_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (beat_q == '0);

endmodule

// File: rtl/sram_master.sv
// SRAM burst master.
// Accepts a burst request (address, length, direction) and drives a
// synchronous SRAM one beat per cycle. Write beats are paced by the
// wd_valid/wd_ready stream; read beats issue every cycle and their data
// returns one cycle later on rd_valid/rd_data.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_we, req_addr, req_len       direction, start address, beats-1
//   wd_valid/wd_ready, wd_data      write data stream
//   rd_valid, rd_data               read data (no backpressure)
//   busy                            burst in progress
//   mem_cs/we/rd, mem_addr, mem_din SRAM command and write data
//   mem_dout                        SRAM registered read data
module sram_master
  import sram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              mem_cs,
  output logic              mem_we,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  state_e            state_q, state_d;
  logic              rd_valid_q, rd_valid_d;
  logic              cnt_load, cnt_step, cnt_last;
  logic [ADDR_W-1:0] cnt_addr;

  sram_burst_cnt #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (cnt_load),
    .step_i    (cnt_step),
    .addr_ld_i (req_addr),
    .len_ld_i  (req_len),
    .addr_o    (cnt_addr),
    .last_o    (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    wd_ready  = 1'b0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    cnt_load  = 1'b0;
    cnt_step  = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cnt_load = 1'b1;
          state_d  = req_we ? WRITE : READ;
        end
      end
      WRITE: begin
        wd_ready = 1'b1;
        // Without write data this is a stall cycle: SRAM idle, counters hold.
        if (wd_valid) begin
          mem_cs   = 1'b1;
          mem_we   = 1'b1;
          mem_addr = cnt_addr;
          mem_din  = wd_data;
          cnt_step = 1'b1;
          if (cnt_last) state_d = IDLE;
        end
      end
      READ: begin
        mem_cs   = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = cnt_addr;
        cnt_step = 1'b1;
        if (cnt_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // SRAM returns read data one cycle after the beat, so valid follows READ by one.
  assign rd_valid_d = (state_q == READ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_valid_q ? mem_dout : '0;

endmodule

// File: tb/tb_sram_master.sv
module tb_sram_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_we;
  logic [7:0] req_addr;
  logic [3:0] req_len;
  logic       wd_valid, wd_ready;
  logic [7:0] wd_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy;
  logic       mem_cs, mem_we, mem_rd;
  logic [7:0] mem_addr, mem_din, mem_dout;

  always #5 clk = ~clk;

  sram_master #(.ADDR_W(8), .DATA_W(8), .LEN_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .wd_valid  (wd_valid),
    .wd_ready  (wd_ready),
    .wd_data   (wd_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .busy      (busy),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  // 8-bit synchronous SRAM: write on clk, read data registered on clk.
  logic [7:0] sram [256];
  always @(posedge clk) begin
    if (mem_cs && mem_we) sram[mem_addr] <= mem_din;
    if (mem_cs && mem_rd) mem_dout <= sram[mem_addr];
  end

  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Command-level protocol checks on every cycle.
  always @(negedge clk) begin
    #3;
    chk("never_we_and_rd", 32'(mem_we & mem_rd), 0);
    chk("we_rd_need_cs", 32'((mem_we | mem_rd) & ~mem_cs), 0);
  end

  logic [7:0] wdat  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic       gv    [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] gd    [5] = '{8'hA1, 8'hEE, 8'hB2, 8'hEE, 8'hC3};
  logic [7:0] faddr [3] = '{8'hFE, 8'hFF, 8'h00};
  logic [7:0] fdat  [3] = '{8'hA1, 8'hB2, 8'hC3};

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
    wd_valid = 1'b0; wd_data = '0;

    // Reset state
    #2;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_cs", 32'(mem_cs), 0);
    chk("rst_wd_ready", 32'(wd_ready), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Write burst 0x10, 4 beats, continuous data
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_len = 4'd3;
    #1 chk("wr_req_ready", 32'(req_ready), 1);
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wd_valid = 1'b1; wd_data = wdat[k];
      #1;
      chk("wr_busy", 32'(busy), 1);
      chk("wr_wd_ready", 32'(wd_ready), 1);
      chk("wr_cs", 32'(mem_cs), 1);
      chk("wr_we", 32'(mem_we), 1);
      chk("wr_rd", 32'(mem_rd), 0);
      chk("wr_addr", 32'(mem_addr), 32'(8'h10 + k));
      chk("wr_din", 32'(mem_din), 32'(wdat[k]));
      tick();
    end
    wd_valid = 1'b0;
    #1;
    chk("wr_done_busy", 32'(busy), 0);
    chk("wr_done_ready", 32'(req_ready), 1);
    chk("wr_done_cs", 32'(mem_cs), 0);
    chk("wr_done_addr", 32'(mem_addr), 0);
    // Write data offered in IDLE is ignored
    wd_valid = 1'b1; wd_data = 8'h5A;
    #1;
    chk("idle_wd_ready", 32'(wd_ready), 0);
    chk("idle_wd_we", 32'(mem_we), 0);
    chk("idle_wd_din", 32'(mem_din), 0);
    tick();
    wd_valid = 1'b0;

    // Read burst 0x10, 4 beats
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10; req_len = 4'd3;
    #1;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rd_cs", 32'(mem_cs), 1);
      chk("rd_rd", 32'(mem_rd), 1);
      chk("rd_we", 32'(mem_we), 0);
      chk("rd_addr", 32'(mem_addr), 32'(8'h10 + k));
      chk("rd_valid_beat", 32'(rd_valid), (k > 0) ? 1 : 0);
      chk("rd_data_beat", 32'(rd_data), (k > 0) ? 32'(wdat[(k > 0) ? k - 1 : 0]) : 0);
      tick();
    end
    #1;
    chk("rd_tail_busy", 32'(busy), 0);
    chk("rd_tail_rd", 32'(mem_rd), 0);
    chk("rd_tail_valid", 32'(rd_valid), 1);
    chk("rd_tail_data", 32'(rd_data), 32'h44);
    tick();
    #1;
    chk("rd_after_valid", 32'(rd_valid), 0);
    chk("rd_after_data", 32'(rd_data), 0);
    tick();

    // Gapped write across the address wrap
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'hFE; req_len = 4'd2;
    #1;
    tick();
    req_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      wd_valid = gv[k]; wd_data = gd[k];
      #1;
      chk("gap_busy", 32'(busy), 1);
      chk("gap_cs", 32'(mem_cs), 32'(gv[k]));
      chk("gap_we", 32'(mem_we), 32'(gv[k]));
      chk("gap_addr", 32'(mem_addr), gv[k] ? 32'(faddr[n]) : 0);
      chk("gap_din", 32'(mem_din), gv[k] ? 32'(gd[k]) : 0);
      if (gv[k]) n++;
      tick();
    end
    wd_valid = 1'b0;
    #1;
    chk("gap_done_busy", 32'(busy), 0);
    tick();

    // Readback across the wrap
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'hFE; req_len = 4'd2;
    #1;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("wrap_rd_addr", 32'(mem_addr), 32'(faddr[k]));
      chk("wrap_rd_valid", 32'(rd_valid), (k > 0) ? 1 : 0);
      chk("wrap_rd_data", 32'(rd_data), (k > 0) ? 32'(fdat[(k > 0) ? k - 1 : 0]) : 0);
      tick();
    end
    #1;
    chk("wrap_tail_valid", 32'(rd_valid), 1);
    chk("wrap_tail_data", 32'(rd_data), 32'hC3);
    tick();

    // Back-to-back single-beat reads at earliest acceptance
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10; req_len = 4'd0;
    #1 chk("b2b_ready0", 32'(req_ready), 1);
    tick();
    req_addr = 8'h11;
    #1;
    chk("b2b_ready_busy", 32'(req_ready), 0);
    chk("b2b_addr0", 32'(mem_addr), 32'h10);
    tick();
    #1;
    chk("b2b_ready1", 32'(req_ready), 1);
    chk("b2b_valid0", 32'(rd_valid), 1);
    chk("b2b_data0", 32'(rd_data), 32'h11);
    tick();
    req_valid = 1'b0;
    #1;
    chk("b2b_addr1", 32'(mem_addr), 32'h11);
    chk("b2b_gap_valid", 32'(rd_valid), 0);
    tick();
    #1;
    chk("b2b_valid1", 32'(rd_valid), 1);
    chk("b2b_data1", 32'(rd_data), 32'h22);
    tick();

    // Reset during second beat of an 8-beat read
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10; req_len = 4'd7;
    #1;
    tick();
    req_valid = 1'b0;
    #1 chk("abort_beat0_addr", 32'(mem_addr), 32'h10);
    tick();
    #1;
    chk("abort_beat1_addr", 32'(mem_addr), 32'h11);
    chk("abort_beat1_valid", 32'(rd_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_cs", 32'(mem_cs), 0);
    chk("abort_rd", 32'(mem_rd), 0);
    chk("abort_addr", 32'(mem_addr), 0);
    chk("abort_rd_valid", 32'(rd_valid), 0);
    chk("abort_rd_data", 32'(rd_data), 0);
    chk("abort_req_ready", 32'(req_ready), 1);
    chk("abort_busy", 32'(busy), 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("post_rst_valid", 32'(rd_valid), 0);
      chk("post_rst_cs", 32'(mem_cs), 0);
      chk("post_rst_busy", 32'(busy), 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
